// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared symbol codes, sizes and FSM states for the WS2812 frame sequencer
package ws2812_pkg;

    localparam logic [1:0] GEN_RET  = 2'b00;
    localparam logic [1:0] GEN_BIT0 = 2'b10;
    localparam logic [1:0] GEN_BIT1 = 2'b11;

    localparam int BITS_PER_LED = 24;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        RET
    } state_e;

    // Map one pixel bit onto the bitGenerator NZR mode code.
    function automatic logic [1:0] bit_mode(input logic b);
        return b ? GEN_BIT1 : GEN_BIT0;
    endfunction

endpackage

// File: rtl/ws2812_pixel_scaler.sv
// rtl/ws2812_pixel_scaler.sv - combinational per-channel brightness scaler for GRB pixels
module ws2812_pixel_scaler (
    input  logic [23:0] pix_i,
    input  logic [7:0]  scale_i,
    output logic [23:0] pix_o
);

    // c * (scale + 1) fits in 16 bits, so scale 255 is an exact identity.
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] s);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, s} + 16'd1);
        return prod[15:8];
    endfunction

    // Scale G, R and B independently.
    always_comb begin
        pix_o = {scale_ch(pix_i[23:16], scale_i),
                 scale_ch(pix_i[15:8],  scale_i),
                 scale_ch(pix_i[7:0],   scale_i)};
    end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// rtl/ws2812_frame_sequencer.sv - frame sequencer driving bitGenerator; optional WS2812_BRIGHTNESS_EN scaling
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS  = 8,
    parameter int ADDR_W    = 3,
    parameter int RET_COUNT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]        brightness,
`endif
    input  logic [23:0]       pixData,
    input  logic              genDone,
    output logic              busy,
    output logic              frameDone,
    output logic [ADDR_W-1:0] pixAddr,
    output logic [1:0]        genMode,
    output logic              doGen
);

    localparam int RET_W = (RET_COUNT > 1) ? $clog2(RET_COUNT) : 1;
    localparam logic [ADDR_W-1:0] LAST_LED = ADDR_W'(NUM_LEDS - 1);
    localparam logic [RET_W-1:0]  LAST_RET = RET_W'(RET_COUNT - 1);
    localparam logic [4:0]        LAST_BIT = 5'(BITS_PER_LED - 1);

    state_e            state_q, state_d;
    logic [23:0]       shift_q, shift_d;
    logic [23:0]       hold_q, hold_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] led_cnt_q, led_cnt_d;
    logic [RET_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [1:0]        gen_mode_q, gen_mode_d;
    logic              do_gen_q, do_gen_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    // pf1: prefetch address just issued; pf2: its read data is now on pixData
    logic              pf1_q, pf1_d;
    logic              pf2_q, pf2_d;
    logic [23:0]       pix_in;

`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] bright_q, bright_d;

    ws2812_pixel_scaler u_scaler (
        .pix_i   (pixData),
        .scale_i (bright_q),
        .pix_o   (pix_in)
    );
`else
    assign pix_in = pixData;
`endif

    // Next-state and output decode; every register defaults to holding.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        bit_cnt_d    = bit_cnt_q;
        led_cnt_d    = led_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        pix_addr_d   = pix_addr_q;
        gen_mode_d   = gen_mode_q;
        do_gen_d     = do_gen_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        pf1_d        = 1'b0;
        pf2_d        = pf1_q;
`ifdef WS2812_BRIGHTNESS_EN
        bright_d     = bright_q;
`endif

        // Next pixel lands in the holding register well before the current one drains.
        if (pf2_q) begin
            hold_d = pix_in;
        end

        case (state_q)
            IDLE: begin
                pix_addr_d = '0;
                if (start) begin
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end

            FETCH: begin
`ifdef WS2812_BRIGHTNESS_EN
                bright_d = brightness;
`endif
                state_d = LOAD;
            end

            LOAD: begin
                shift_d    = pix_in;
                bit_cnt_d  = LAST_BIT;
                led_cnt_d  = '0;
                gen_mode_d = bit_mode(pix_in[23]);
                do_gen_d   = 1'b1;
                if (NUM_LEDS > 1) begin
                    pix_addr_d = ADDR_W'(1);
                    pf1_d      = 1'b1;
                end
                state_d = SEND;
            end

            SEND: begin
                if (genDone) begin
                    if (bit_cnt_q != 5'd0) begin
                        shift_d    = shift_q << 1;
                        bit_cnt_d  = bit_cnt_q - 5'd1;
                        gen_mode_d = bit_mode(shift_q[22]);
                    end else if (led_cnt_q < LAST_LED) begin
                        shift_d    = hold_q;
                        led_cnt_d  = led_cnt_q + ADDR_W'(1);
                        bit_cnt_d  = LAST_BIT;
                        gen_mode_d = bit_mode(hold_q[23]);
                        // pixAddr already points at led+1; step only if led+2 exists
                        if ((led_cnt_q + ADDR_W'(1)) < LAST_LED) begin
                            pix_addr_d = pix_addr_q + ADDR_W'(1);
                            pf1_d      = 1'b1;
                        end
                    end else begin
                        gen_mode_d = GEN_RET;
                        ret_cnt_d  = '0;
                        state_d    = RET;
                    end
                end
            end

            RET: begin
                if (genDone) begin
                    if (ret_cnt_q == LAST_RET) begin
                        do_gen_d     = 1'b0;
                        gen_mode_d   = GEN_RET;
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        pix_addr_d   = '0;
                        state_d      = IDLE;
                    end else begin
                        ret_cnt_d = ret_cnt_q + RET_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            bit_cnt_q    <= '0;
            led_cnt_q    <= '0;
            ret_cnt_q    <= '0;
            pix_addr_q   <= '0;
            gen_mode_q   <= GEN_RET;
            do_gen_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pf1_q        <= 1'b0;
            pf2_q        <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
            bright_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            bit_cnt_q    <= bit_cnt_d;
            led_cnt_q    <= led_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            pix_addr_q   <= pix_addr_d;
            gen_mode_q   <= gen_mode_d;
            do_gen_q     <= do_gen_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pf1_q        <= pf1_d;
            pf2_q        <= pf2_d;
`ifdef WS2812_BRIGHTNESS_EN
            bright_q     <= bright_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign frameDone = frame_done_q;
    assign pixAddr   = pix_addr_q;
    assign genMode   = gen_mode_q;
    assign doGen     = do_gen_q;

endmodule

// File: doc/ws2812_frame_sequencer.md
# ws2812_frame_sequencer

Frame-level controller for the WS2812B bit generator. On a start request it reads `NUM_LEDS` 24-bit GRB pixels from a synchronous-read pixel memory and issues one NZR symbol per bit, MSB first, through the `genMode`/`doGen`/`genDone` handshake. It then issues `RET_COUNT` latch (RET) symbols and reports frame completion. It sits between the pixel frame buffer and `bitGenerator`, and is the only driver of `bitGenerator`'s control inputs.

## Interface
- `NUM_LEDS`, 8: pixels per frame, minimum 1.
- `ADDR_W`, 3: pixel address width; must satisfy `2**ADDR_W >= NUM_LEDS`.
- `RET_COUNT`, 1: number of RET symbols (genDone pulses in mode 00) per frame latch, minimum 1.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `frameDone`.
- `frameDone`  out  1  one-cycle pulse at end of frame.
- `pixAddr`  out  ADDR_W  pixel memory read address.
- `pixData`  in  24  pixel memory read data; valid 1 cycle after `pixAddr`. Layout is G[23:16], R[15:8], B[7:0].
- `genMode`  out  2  to bitGenerator: 00 RET, 10 NZR zero, 11 NZR one; 01 is never driven.
- `doGen`  out  1  to bitGenerator: enables symbol generation.
- `genDone`  in  1  from bitGenerator: one-cycle pulse marking the last cycle of a symbol.

## Operation
- States:
  - IDLE: `pixAddr` = 0. When `start` = 1, go to FETCH.
  - FETCH: one cycle of memory latency, then go to LOAD.
  - LOAD: capture `pixData` into the 24-bit shift register; set `bitCnt` = 23 and `ledCnt` = 0. Drive `genMode` = {1, shift[23]} and `doGen` = 1. If `NUM_LEDS` > 1, drive `pixAddr` = 1 (prefetch). Go to SEND.
  - SEND, on `genDone`:
    - `bitCnt` > 0: shift left by 1, decrement `bitCnt`, present the next bit.
    - `bitCnt` = 0 and `ledCnt` < `NUM_LEDS`-1: move the holding register into the shift register, increment `ledCnt`, set `bitCnt` = 23, advance `pixAddr` when a further pixel exists.
    - Otherwise: `genMode` = 00, clear `retCnt`, go to RET.
  - RET: count `genDone` pulses. When the count reaches `RET_COUNT`: `doGen` = 0, `genMode` = 00, pulse `frameDone`, go to IDLE.
- The holding register captures `pixData` one cycle after each prefetch address is issued. This guarantees no gap between the last bit of a pixel and the first bit of the next.
- `pixAddr` never exceeds `NUM_LEDS`-1; it holds its value after the final prefetch.
- `start` is ignored outside IDLE. A `start` held high through the IDLE return begins a new frame on the next cycle.
- `genDone` is ignored in IDLE, FETCH and LOAD.
- `reset` in any state: on the next edge, enter IDLE with all outputs at reset values. The in-flight symbol is abandoned.
- Reset values: `doGen` 0, `genMode` 00, `busy` 0, `frameDone` 0, `pixAddr` 0, all counters 0.

## Timing
- `start` accepted at edge 0 → FETCH at 1 → LOAD at 2 → first `genMode` and `doGen` = 1 visible after edge 2 (2-cycle start latency).
- `genDone` high in cycle n → the new `genMode` is registered at the end of n and visible in n+1. `bitGenerator` must sample `genMode` at symbol start, not at the genDone cycle.
- Frame length is 24·`NUM_LEDS` data symbols plus `RET_COUNT` RET symbols.
- `frameDone` is asserted in the cycle after the final RET `genDone`. `busy` falls in that same cycle.

## Configuration
- `WS2812_BRIGHTNESS_EN` defined:
  - Adds input port `brightness`, 8 bits, sampled in FETCH and held for the whole frame.
  - Each channel c is replaced by (c·(brightness+1))>>8, computed at 16-bit width and truncated to 8 bits.
  - The scaling is applied on the path from `pixData` into both the shift register and the holding register.
  - brightness = 255 is an identity; brightness = 0 gives c>>8 = 0.
- Undefined: no port; pixels pass through unmodified.

## Structure
- Package `ws2812_pkg`:
  - `GEN_RET` = 2'b00, `GEN_BIT0` = 2'b10, `GEN_BIT1` = 2'b11.
  - `BITS_PER_LED` = 24.
  - State enum IDLE, FETCH, LOAD, SEND, RET.
- Sub-module `ws2812_pixel_scaler`: combinational 24-bit three-channel scaler. It is instantiated only under `WS2812_BRIGHTNESS_EN`.

## Test plan
- `NUM_LEDS`=2, memory {24'hFF0000, 24'h000001}, `start` pulse → `genMode` sequence 11×8, 10×16, 10×23, 11×1, then 00 ×`RET_COUNT`; one `frameDone` pulse; `busy` high throughout.
- Behavioural bitGenerator model with back-to-back `genDone` every 125 cycles → no idle cycle between pixels; `pixAddr` never exceeds 1.
- `start` held high during a frame → the frame is not restarted; a second frame begins 1 cycle after `frameDone`.
- `reset` asserted mid-SEND on LED 1, bit 10 → next edge gives `doGen` = 0, `genMode` = 00, `busy` = 0, `pixAddr` = 0; a following `start` replays from LED 0, bit 23.
- Spurious `genDone` pulses in IDLE → no output change and no `frameDone`.
- `WS2812_BRIGHTNESS_EN`, brightness = 8'h7F, pixel 24'hFF80_02 → transmitted 24'h7F40_01.
